// File: rtl/console_uart_tx_pkg.sv
// Shared definitions for the console UART: bus direction codes, register offsets,
// status bit positions and TX state encodings.
`ifndef READ
`define READ 1'b0
`endif
`ifndef WRITE
`define WRITE 1'b1
`endif

package console_uart_tx_pkg;

  localparam logic [2:0] CONSOLE_DATA_OFFSET   = 3'd0;
  localparam logic [2:0] CONSOLE_STATUS_OFFSET = 3'd4;

  localparam int STAT_ACTIVE_BIT = 0;
  localparam int STAT_FULL_BIT   = 1;
  localparam int STAT_EMPTY_BIT  = 2;
  localparam int STAT_OVF_BIT    = 3;
  localparam int STAT_COUNT_LSB  = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/console_fifo.sv
// Show-ahead 8-bit character FIFO; pop on empty and push on full (without a
// same-cycle pop) are ignored.
module console_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               data_in,
  input  logic                     pop,
  output logic [7:0]               data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q,  count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == NW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign data_out = mem_q[rd_ptr_q];

  // A pop frees the slot the same cycle, so a full FIFO still accepts a push then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/console_uart_tx.sv
// Memory-mapped console: byte writes to the data register are queued and sent 8N1
// on txd; a status register reports FIFO/line state and a sticky overflow flag.
module console_uart_tx
  import console_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000,
  parameter int          CLK_DIV      = 16,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_enable,
  input  logic        bus_state,
  input  logic [31:0] bus_address,
  input  logic [3:0]  bus_frame_mask,
  input  logic [31:0] bus_write_data,
  output logic [31:0] bus_read_data,
  output logic        bus_read_valid,
  output logic        txd,
  output logic        tx_active
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int            NW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          active_q, active_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   rd_dat_q, rd_dat_d;
  logic          rd_vld_q;

  logic          sel, is_status, data_wr, ovf_clr, rd_req;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dat;
  logic [NW-1:0] fifo_count;
  logic [31:0]   status_w;
  logic          unused_bits;

  // Registers are decoded per 32-bit word; bus_address[2] picks data vs. status.
  assign sel       = bus_enable && (bus_address[31:3] == BASE_ADDRESS[31:3]);
  assign is_status = bus_address[2] == CONSOLE_STATUS_OFFSET[2];
  assign data_wr   = sel && !is_status && (bus_state == `WRITE) && bus_frame_mask[3];
  assign ovf_clr   = sel && is_status && (bus_state == `WRITE) && bus_frame_mask[3]
                     && bus_write_data[STAT_OVF_BIT];
  assign rd_req    = sel && (bus_state == `READ);

  assign unused_bits = ^{bus_write_data[31:8], bus_address[1:0], bus_frame_mask[2:0]};

  console_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (data_wr),
    .data_in  (bus_write_data[7:0]),
    .pop      (fifo_pop),
    .data_out (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    status_w                                 = '0;
    status_w[STAT_ACTIVE_BIT]                = active_q;
    status_w[STAT_FULL_BIT]                  = fifo_full;
    status_w[STAT_EMPTY_BIT]                 = fifo_empty;
    status_w[STAT_OVF_BIT]                   = overflow_q;
    status_w[STAT_COUNT_LSB +: NW]           = fifo_count;
  end

  // A push into a full FIFO is only lost when the transmitter is not popping that cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr)
      overflow_d = 1'b0;
    else if (data_wr && fifo_full && !fifo_pop)
      overflow_d = 1'b1;
    rd_dat_d = (rd_req && is_status) ? status_w : 32'h0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dat;
          cnt_d    = '0;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (idx_q == 3'd7) state_d = TX_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Line outputs are registered from the next state so txd never glitches.
    txd_d    = 1'b1;
    active_d = (state_d != TX_IDLE);
    case (state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = shift_d[idx_d];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= TX_IDLE;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      shift_q    <= 8'h00;
      txd_q      <= 1'b1;
      active_q   <= 1'b0;
      overflow_q <= 1'b0;
      rd_dat_q   <= 32'h0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      active_q   <= active_d;
      overflow_q <= overflow_d;
      rd_dat_q   <= rd_dat_d;
      rd_vld_q   <= rd_req;
    end
  end

  assign txd            = txd_q;
  assign tx_active      = active_q;
  assign bus_read_data  = rd_dat_q;
  assign bus_read_valid = rd_vld_q;

endmodule

// File: tb/tb_console_uart_tx.sv
// Self-checking bench for console_uart_tx: a UART receiver model decodes txd into a
// queue that is compared against the characters the stimulus expects to be sent.
module tb_console_uart_tx;

  localparam int          CLK_DIV    = 4;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] BASE       = 32'h1000_0000;
  localparam logic [31:0] STAT_ADDR  = 32'h1000_0004;
  localparam logic        BUS_RD     = 1'b0;
  localparam logic        BUS_WR     = 1'b1;
  localparam int          FRAME      = 10 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bus_enable = 1'b0;
  logic        bus_state = 1'b0;
  logic [31:0] bus_address = 32'h0;
  logic [3:0]  bus_frame_mask = 4'h0;
  logic [31:0] bus_write_data = 32'h0;
  logic [31:0] bus_read_data;
  logic        bus_read_valid;
  logic        txd;
  logic        tx_active;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         start_cyc_q[$];
  int         cyc = 0;

  console_uart_tx #(
    .BASE_ADDRESS (BASE),
    .CLK_DIV      (CLK_DIV),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus_enable     (bus_enable),
    .bus_state      (bus_state),
    .bus_address    (bus_address),
    .bus_frame_mask (bus_frame_mask),
    .bus_write_data (bus_write_data),
    .bus_read_data  (bus_read_data),
    .bus_read_valid (bus_read_valid),
    .txd            (txd),
    .tx_active      (tx_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver: start detected at the first low sample, then each bit sampled mid-slot.
  bit         rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_shift = 8'h00;
  int         rx_framing_err = 0;

  always @(negedge clk) begin
    if (!reset) begin
      rx_busy <= 1'b0;
    end else if (!rx_busy) begin
      if (txd === 1'b0) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 0;
        start_cyc_q.push_back(cyc);
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      for (int i = 0; i < 8; i++)
        if (rx_cnt + 1 == CLK_DIV * (1 + i) + CLK_DIV / 2) rx_shift[i] <= txd;
      if (rx_cnt + 1 == 9 * CLK_DIV + CLK_DIV / 2) begin
        rx_busy <= 1'b0;
        if (txd !== 1'b1) rx_framing_err <= rx_framing_err + 1;
        rx_q.push_back(rx_shift);
      end
    end
  end

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    bus_enable     = 1'b1;
    bus_state      = BUS_WR;
    bus_address    = addr;
    bus_frame_mask = mask;
    bus_write_data = data;
    @(negedge clk);
    bus_enable     = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic vld);
    bus_enable     = 1'b1;
    bus_state      = BUS_RD;
    bus_address    = addr;
    bus_frame_mask = 4'hF;
    @(negedge clk);
    bus_enable     = 1'b0;
    data = bus_read_data;
    vld  = bus_read_valid;
  endtask

  task automatic check_status(input string name, input logic [31:0] expd);
    logic [31:0] d;
    logic        v;
    bus_read(STAT_ADDR, d, v);
    checks++;
    if (v !== 1'b1 || d !== expd) begin
      errors++;
      $display("FAIL %s: status valid=%0b data=%08h, required valid=1 data=%08h", name, v, d, expd);
    end
  endtask

  task automatic wait_drain(input string name);
    int         budget;
    int         n;
    logic [7:0] e;
    logic [7:0] r;
    budget = exp_q.size() * (FRAME + 1) + 50;
    n = 0;
    while ((rx_q.size() < exp_q.size() || tx_active !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_timeout: received %0d chars, required %0d", name, rx_q.size(), exp_q.size());
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: received %0d chars, required %0d", name, rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r !== e) begin
        errors++;
        $display("FAIL %s_char: received %02h, required %02h", name, r, e);
      end
    end
    exp_q.delete();
    rx_q.delete();
    checks++;
    if (rx_framing_err != 0) begin
      errors++;
      $display("FAIL %s_stop_bit: framing errors %0d, required 0", name, rx_framing_err);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1 || tx_active !== 1'b0 || bus_read_valid !== 1'b0 || bus_read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: txd=%0b active=%0b rvld=%0b rdata=%08h, required 1 0 0 0",
               txd, tx_active, bus_read_valid, bus_read_data);
    end
    reset = 1'b1;
    @(negedge clk);
    check_status("reset_status", 32'h0000_0004);
  endtask

  task automatic test_single_char();
    logic [9:0] frame;
    frame = {1'b1, 8'h41, 1'b0};
    exp_q.push_back(8'h41);
    bus_write(BASE, 4'b1000, 32'hAABB_CC41);
    checks++;
    if (txd !== 1'b1 || tx_active !== 1'b0) begin
      errors++;
      $display("FAIL single_pre_pop: txd=%0b active=%0b, required 1 0", txd, tx_active);
    end
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      checks++;
      if (txd !== frame[j / CLK_DIV] || tx_active !== 1'b1) begin
        errors++;
        $display("FAIL single_bit cycle %0d: txd=%0b active=%0b, required %0b 1",
                 j, txd, tx_active, frame[j / CLK_DIV]);
      end
    end
    @(negedge clk);
    checks++;
    if (txd !== 1'b1 || tx_active !== 1'b0) begin
      errors++;
      $display("FAIL single_post_frame: txd=%0b active=%0b, required 1 0", txd, tx_active);
    end
    wait_drain("single");
  endtask

  task automatic test_lane_gating();
    int lows;
    bus_write(BASE, 4'b0001, 32'h0000_0041);
    bus_write(BASE, 4'b0110, 32'h0000_0041);
    check_status("lane_status", 32'h0000_0004);
    lows = 0;
    for (int j = 0; j < 3 * FRAME; j++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL lane_txd_idle: low cycles=%0d frames=%0d, required 0 0", lows, rx_q.size());
    end
  endtask

  task automatic test_reads();
    logic [31:0] d;
    logic        v;
    bus_read(BASE, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL data_read: valid=%0b data=%08h, required 1 00000000", v, d);
    end
    check_status("read_status", 32'h0000_0004);
    @(negedge clk);
    checks++;
    if (bus_read_valid !== 1'b0 || bus_read_data !== 32'h0) begin
      errors++;
      $display("FAIL read_clear: valid=%0b data=%08h, required 0 00000000", bus_read_valid, bus_read_data);
    end
    bus_read(32'h1000_0008, d, v);
    checks++;
    if (v !== 1'b0 || d !== 32'h0) begin
      errors++;
      $display("FAIL read_other_addr: valid=%0b data=%08h, required 0 00000000", v, d);
    end
    bus_read(32'h2000_0004, d, v);
    checks++;
    if (v !== 1'b0) begin
      errors++;
      $display("FAIL read_far_addr: valid=%0b, required 0", v);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(8'(8'h10 + i));
      bus_write(BASE, 4'b1000, 32'h10 + i);
    end
    check_status("ovf_status", 32'h0000_040B);
    bus_write(STAT_ADDR, 4'b1000, 32'h0000_0008);
    check_status("ovf_cleared", 32'h0000_0403);
    wait_drain("ovf");
    check_status("ovf_idle", 32'h0000_0004);
  endtask

  task automatic test_full_simultaneous_pop();
    int base;
    int diff;
    base = start_cyc_q.size();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'(8'h20 + i));
      bus_write(BASE, 4'b1000, 32'h20 + i);
    end
    // First write was sampled 4 edges ago; the second pop lands 42 edges after it.
    repeat (36) @(negedge clk);
    check_status("full_before_pop", 32'h0000_0403);
    exp_q.push_back(8'h25);
    bus_write(BASE, 4'b1000, 32'h25);
    check_status("full_after_pop", 32'h0000_0403);
    wait_drain("full_pop");
    checks++;
    if (start_cyc_q.size() - base != 6) begin
      errors++;
      $display("FAIL b2b_frames: frames %0d, required 6", start_cyc_q.size() - base);
    end
    for (int i = base + 1; i < start_cyc_q.size(); i++) begin
      diff = start_cyc_q[i] - start_cyc_q[i-1];
      checks++;
      if (diff != FRAME + 1) begin
        errors++;
        $display("FAIL b2b_period: frame spacing %0d cycles, required %0d", diff, FRAME + 1);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int frames;
    int lows;
    frames = start_cyc_q.size();
    bus_write(BASE, 4'b1000, 32'h52);
    repeat (1 + CLK_DIV + 3 * CLK_DIV) @(negedge clk);
    checks++;
    if (tx_active !== 1'b1 || txd !== 1'b0) begin
      errors++;
      $display("FAIL midframe_bit3: active=%0b txd=%0b, required 1 0", tx_active, txd);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || tx_active !== 1'b0) begin
      errors++;
      $display("FAIL midframe_async: txd=%0b active=%0b, required 1 0", txd, tx_active);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_status("midframe_status", 32'h0000_0004);
    lows = 0;
    for (int j = 0; j < 2 * FRAME; j++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0 || start_cyc_q.size() != frames + 1 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL midframe_residual: low cycles=%0d new frames=%0d chars=%0d, required 0 1 0",
               lows, start_cyc_q.size() - frames, rx_q.size());
    end
  endtask

  task automatic test_wrap_around();
    logic [7:0] c;
    for (int i = 0; i < 3 * FIFO_DEPTH; i++) begin
      c = 8'($urandom_range(0, 255));
      exp_q.push_back(c);
      bus_write(BASE, 4'b1000, {24'hFFFFFF, c});
      if (i >= FIFO_DEPTH - 1) repeat (FRAME) @(negedge clk);
    end
    wait_drain("wrap");
    check_status("wrap_status", 32'h0000_0004);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_char();
    test_lane_gating();
    test_reads();
    test_overflow();
    test_full_simultaneous_pop();
    test_reset_mid_frame();
    test_wrap_around();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
